disp_value_bcd: RTL and testbench

Upstream feeder for the eight-digit seven-segment presenter. It accepts a 16-bit value written by the CPU's display MMIO port. It then produces the packed 32-bit nibble vector that the presenter scans out, one nibble per digit, digit 0 in bits [3:0]. In decimal mode the value is converted to BCD with a sequential double-dabble engine, one iteration per cycle. In hex mode the value passes straight through.

---
 rtl/disp_value_bcd_pkg.sv | 23 ++
 rtl/disp_value_bcd_bcd_add3.sv | 19 +
 rtl/disp_value_bcd.sv | 131 +++++++++++++
 tb/tb_disp_value_bcd.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/disp_value_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_value_bcd_pkg
//  Description : Shared constants for the display value feeder: default
//                widths, nibble width and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_value_bcd_pkg;

  // Default geometry of the feeder
  localparam int C_DATA_W = 16;  // binary input width
  localparam int C_NDIG   = 5;   // BCD digits produced
  localparam int C_OUT_W  = 32;  // nibble vector width towards the presenter
  localparam int C_NIB_W  = 4;   // bits per displayed digit

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CONV = 2'd1;
  localparam state_t S_LOAD = 2'd2;

endpackage : disp_value_bcd_pkg
`default_nettype wire

// File: rtl/disp_value_bcd_bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble digit correction. Adds 3 to a BCD digit that
//                is 5 or more so the following left shift carries correctly
//                into the next decimal digit.
//  Ports       : i_digit - BCD digit before correction
//                o_digit - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/disp_value_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : disp_value_bcd
//  Description : Feeder for the eight-digit seven-segment presenter. Accepts a
//                binary value from the display MMIO port and produces a packed
//                nibble vector (digit 0 in bits [3:0]). Decimal mode converts
//                with a sequential double-dabble engine, one iteration per
//                clock; hex mode passes the value straight through.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous active-high reset
//                wr_en    - write strobe (one-cycle pulse)
//                wr_data  - value to display
//                dec_mode - 1 = decimal (BCD), 0 = hex, sampled with wr_en
//                disp_val - nibble vector to presenter (registered)
//                busy     - a write is being processed
//                done     - one-cycle pulse when disp_val was just updated
//                ovr      - sticky flag: a write was dropped while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_value_bcd
  import disp_value_bcd_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int NDIG   = C_NDIG,
  parameter int OUT_W  = C_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dec_mode,
  output logic [OUT_W-1:0]  disp_val,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

  localparam int BCD_W = C_NIB_W * NDIG;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dec;
  logic [OUT_W-1:0]   r_disp;
  logic               r_done;
  logic               r_ovr;

  logic [BCD_W-1:0]   w_bcd_adj;
  logic [OUT_W-1:0]   w_bcd_ext;
  logic [OUT_W-1:0]   w_hex_ext;

  // Per-digit add-3 correction applied before every shift
  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_bcd    [g*C_NIB_W +: C_NIB_W]),
      .o_digit (w_bcd_adj[g*C_NIB_W +: C_NIB_W])
    );
  end

  // Zero-extended views of the two possible display sources
  always_comb begin
    w_bcd_ext = '0;
    w_bcd_ext[BCD_W-1:0] = r_bcd;
    w_hex_ext = '0;
    w_hex_ext[DATA_W-1:0] = r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_disp  <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Any write arriving outside IDLE is dropped but remembered
      if (wr_en && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (wr_en) begin
            r_shift <= wr_data;
            r_dec   <= dec_mode;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
            r_state <= dec_mode ? S_CONV : S_LOAD;
          end
        end

        S_CONV: begin
          // Corrected BCD shifts left, taking the shift register MSB
          r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[DATA_W-1]};
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          // In hex mode the shift register still holds the untouched write
          r_disp  <= r_dec ? w_bcd_ext : w_hex_ext;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign disp_val = r_disp;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign ovr      = r_ovr;

endmodule : disp_value_bcd
`default_nettype wire

// File: tb/tb_disp_value_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_value_bcd
//  Description : Scoreboard bench for disp_value_bcd. Stimulus pushes the
//                expected display value and latency for every accepted write;
//                an independent monitor pops and compares on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_value_bcd;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        dec_mode;
  logic [31:0] disp_val;
  logic        busy;
  logic        done;
  logic        ovr;

  typedef struct {
    logic [31:0] val;
    int          e_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_e = 0;

  disp_value_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dec_mode (dec_mode),
    .disp_val (disp_val),
    .busy     (busy),
    .done     (done),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: disp_val=%h with no pending write", disp_val);
      end else begin
        e = sb.pop_front();
        if (disp_val !== e.val || (cyc - e.e_cyc) != e.lat) begin
          errors++;
          $display("FAIL done_value: got %h after %0d cycles, expected %h after %0d cycles",
                   disp_val, cyc - e.e_cyc, e.val, e.lat);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; wr_en is sampled at the next posedge (edge E).
  // Returns at the negedge following E.
  task automatic do_write(input logic [15:0] d, input logic dm, input logic [31:0] exp);
    wr_en = 1'b1; wr_data = d; dec_mode = dm;
    @(negedge clk);
    wr_en = 1'b0;
    last_e = cyc;
    sb.push_back('{val: exp, e_cyc: cyc, lat: (dm ? 17 : 1)});
    check1("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    int e1;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; dec_mode = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_disp", disp_val, 32'h0);
    check1("rst_busy", {31'd0, busy}, 32'd0);
    check1("rst_done", {31'd0, done}, 32'd0);
    check1("rst_ovr",  {31'd0, ovr},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic decimal conversions
    do_write(16'd1234, 1'b1, 32'h0000_1234); wait_idle();
    do_write(16'd65535, 1'b1, 32'h0006_5535); wait_idle();
    do_write(16'd0, 1'b1, 32'h0000_0000); wait_idle();

    // Hex passthrough, busy for one cycle only
    do_write(16'hBEEF, 1'b0, 32'h0000_BEEF);
    @(negedge clk);
    check1("hex_busy_fall", {31'd0, busy}, 32'd0);

    // Dropped write during conversion
    do_write(16'd500, 1'b1, 32'h0000_0500);
    repeat (4) @(negedge clk);
    wr_en = 1'b1; wr_data = 16'd999; dec_mode = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check1("ovr_set", {31'd0, ovr}, 32'd1);
    wait_idle();
    check1("ovr_sticky", {31'd0, ovr}, 32'd1);
    e1 = last_e;
    do_write(16'd123, 1'b1, 32'h0000_0123);
    check1("accept_at_e18", last_e - e1, 32'd18);
    check1("ovr_clear", {31'd0, ovr}, 32'd0);
    wait_idle();

    // Asynchronous reset mid-conversion
    wr_en = 1'b1; wr_data = 16'd4321; dec_mode = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check1("arst_disp", disp_val, 32'h0);
    check1("arst_busy", {31'd0, busy}, 32'd0);
    check1("arst_done", {31'd0, done}, 32'd0);
    check1("arst_ovr",  {31'd0, ovr},  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check1("arst_no_done_disp", disp_val, 32'h0);
    do_write(16'd42, 1'b1, 32'h0000_0042); wait_idle();

    // Back-to-back decimal writes
    do_write(16'd7, 1'b1, 32'h0000_0007);
    e1 = last_e;
    wait_idle();
    do_write(16'd10, 1'b1, 32'h0000_0010);
    check1("b2b_spacing", last_e - e1, 32'd18);
    wait_idle();
    repeat (3) @(negedge clk);

    check1("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_disp_value_bcd
`default_nettype wire
